branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
Parametrised branch target buffer with per-entry saturating direction counters. It lets the PC block predict next_pc during fetch instead of waiting for branch/jump resolution in MEM. Fetch looks it up combinationally with the current pc. The resolving stage (EX/MEM) updates it on the clock edge. A mode parameter selects static not-taken or dynamic prediction; hit and mispredict statistics counters support the cpu tracker.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of 2, minimum 2
COUNTER_BITS, 2, width of the per-entry saturating direction counter, minimum 1
PREDICT_MODE, 1, 0 = static not-taken (table still trains), 1 = dynamic counter prediction
STAT_BITS, 32, width of the statistics counters

Ports:
CLK  input  1  clock
nRST  input  1  reset, asynchronous, active-low
lookup_valid  input  1  fetch is presenting a valid pc this cycle
lookup_pc  input  32  fetch pc, word aligned
predict_hit  output  1  valid entry with matching tag for lookup_pc
predict_taken  output  1  predicted taken
predict_target  output  32  predicted next pc
update_en  input  1  a control-flow instruction resolved this cycle
update_pc  input  32  pc of the resolved instruction
update_taken  input  1  actual direction
update_target  input  32  actual taken target, word aligned
update_mispredict  input  1  resolving stage found the prediction wrong
flush_all  input  1  invalidate every entry
hit_count  output  STAT_BITS  lookups with lookup_valid and predict_hit
mispredict_count  output  STAT_BITS  updates with update_en and update_mispredict

Behaviour:
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2].
- Entry holds: valid, tag, target[31:2], counter[COUNTER_BITS-1:0].
- Lookup is combinational, zero latency, and reads registered table state only. There is no bypass from a same-cycle update.
- predict_hit = entry valid and tag match.
- predict_taken = predict_hit and counter MSB, when PREDICT_MODE=1. It is 0 always when PREDICT_MODE=0.
- predict_target = {stored target, 2'b00} when predict_taken, else lookup_pc + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000).
- predict_hit, predict_taken and predict_target are valid regardless of lookup_valid. lookup_valid gates only hit_count.
- Updates apply at posedge CLK when update_en=1.
- Tag hit, taken: counter increments, saturating at all ones; target is overwritten with update_target[31:2].
- Tag hit, not taken: counter decrements, saturating at 0; target is unchanged.
- Miss, taken: the entry is allocated, replacing any alias. valid=1, tag written, target written, counter = weakly taken (MSB=1, other bits 0; i.e. 2'b10).
- Miss, not taken: no table change.
- update_target bits [1:0] are ignored.
- flush_all has priority: at the edge it clears every valid bit and discards any same-cycle update. Counters, tags and targets are don't-care once invalid.
- Statistics counters:
  - hit_count increments by 1 on each edge where lookup_valid and predict_hit are both 1.
  - mispredict_count increments by 1 on each edge where update_en and update_mispredict are both 1.
  - Both saturate at all ones (no wrap).
  - Neither is cleared by flush_all.
- Reset (asynchronous, any time including mid-update):
  - All valid bits = 0, all counters = 0, all tags/targets = 0.
  - hit_count = 0, mispredict_count = 0.
  - Outputs during and after reset: predict_hit=0, predict_taken=0, predict_target = lookup_pc+4.
- An update with update_en=0 has no effect, whatever the other update inputs hold.
- Same index updated on consecutive cycles: each update sees the prior edge's result (read-modify-write per edge).

Test Plan:
1. Reset, lookup_pc=0x00000040, lookup_valid=1 -> predict_hit=0, predict_taken=0, predict_target=0x00000044; hit_count stays 0.
2. Allocate: update_en=1, update_pc=0x40, update_taken=1, update_target=0x100 -> next cycle lookup 0x40 gives hit=1, taken=1, target=0x100; hit_count increments to 1 per valid cycle.
3. Saturation, then retrain:
   - Stimulus: two taken updates to 0x40, then three not-taken updates.
   - Required counter sequence: 10 -> 11 -> 11 -> 10 -> 01 -> 00.
   - Required predict_taken: 1, 1, 1, 1, 0, 0.
4. Alias (ENTRIES=16): after scenario 2, taken update pc=0x80 target=0x200 (same index 0, different tag) -> lookup 0x40 hit=0, target=0x44; lookup 0x80 hit=1, target=0x200.
5. Flush priority and statistics:
   - Stimulus: flush_all=1 together with a taken update to 0x40, then lookup 0x40.
   - Required: hit=0.
   - Stimulus: update_mispredict=1 with update_en=0.
   - Required: mispredict_count unchanged; with update_en=1 it increments by 1.
6. PREDICT_MODE=0 with an allocated entry at 0x40 -> predict_hit=1, predict_taken=0, predict_target=0x44. Assert nRST mid-sequence -> table and counters cleared immediately.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Fetch reads it combinationally; the resolving stage trains it on the clock edge.
module branch_target_buffer #(
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int PREDICT_MODE = 1,
    parameter int STAT_BITS    = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 predict_hit,
    output logic                 predict_taken,
    output logic [31:0]          predict_target,
    input  logic                 update_en,
    input  logic [31:0]          update_pc,
    input  logic                 update_taken,
    input  logic [31:0]          update_target,
    input  logic                 update_mispredict,
    input  logic                 flush_all,
    output logic [STAT_BITS-1:0] hit_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int IDX      = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX;

    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_ZERO = '0;
    localparam logic [COUNTER_BITS-1:0] CNT_WEAK = CNT_ONE << (COUNTER_BITS - 1);
    localparam logic [STAT_BITS-1:0]    STAT_ONE = STAT_BITS'(1);
    localparam logic [STAT_BITS-1:0]    STAT_MAX = '1;

    logic [ENTRIES-1:0]      valid_q;
    logic [TAG_BITS-1:0]     tag_q     [ENTRIES];
    logic [29:0]             target_q  [ENTRIES];
    logic [COUNTER_BITS-1:0] counter_q [ENTRIES];

    logic [IDX-1:0]          lookup_idx;
    logic [TAG_BITS-1:0]     lookup_tag;
    logic [IDX-1:0]          update_idx;
    logic [TAG_BITS-1:0]     update_tag;
    logic                    update_hit;
    logic [COUNTER_BITS-1:0] counter_cur;
    logic [COUNTER_BITS-1:0] counter_next;

    // Low address bits are implied by word alignment and never stored.
    logic unused_low_bits;
    assign unused_low_bits = ^{update_pc[1:0], update_target[1:0]};

    assign lookup_idx = lookup_pc[IDX+1:2];
    assign lookup_tag = lookup_pc[31:IDX+2];
    assign update_idx = update_pc[IDX+1:2];
    assign update_tag = update_pc[31:IDX+2];

    // Lookup sees registered state only; a same-cycle update is not forwarded.
    always_comb begin
        predict_hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        predict_taken  = (PREDICT_MODE != 0) && predict_hit
                         && counter_q[lookup_idx][COUNTER_BITS-1];
        predict_target = predict_taken ? {target_q[lookup_idx], 2'b00}
                                       : lookup_pc + 32'd4;
    end

    always_comb begin
        update_hit   = valid_q[update_idx] && (tag_q[update_idx] == update_tag);
        counter_cur  = counter_q[update_idx];
        counter_next = counter_cur;
        if (update_taken) begin
            if (counter_cur != CNT_MAX) counter_next = counter_cur + CNT_ONE;
        end else begin
            if (counter_cur != CNT_ZERO) counter_next = counter_cur - CNT_ONE;
        end
    end

    // Flush wins over a coincident update; a not-taken miss leaves the table alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                counter_q[i] <= '0;
            end
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (update_en) begin
            if (update_hit) begin
                counter_q[update_idx] <= counter_next;
                if (update_taken) target_q[update_idx] <= update_target[31:2];
            end else if (update_taken) begin
                valid_q[update_idx]   <= 1'b1;
                tag_q[update_idx]     <= update_tag;
                target_q[update_idx]  <= update_target[31:2];
                counter_q[update_idx] <= CNT_WEAK;
            end
        end
    end

    // Statistics saturate and survive flushes; only reset clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count        <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_valid && predict_hit && (hit_count != STAT_MAX))
                hit_count <= hit_count + STAT_ONE;
            if (update_en && update_mispredict && (mispredict_count != STAT_MAX))
                mispredict_count <= mispredict_count + STAT_ONE;
        end
    end

endmodule
